// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable divider: one-cycle tick per period, a square-wave clk_out,
// graceful start/stop sequencing and ratio changes staged to period boundaries.
module clk_div_ctrl #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             clk_out,
    output logic             running,
    output logic [7:0]       tick_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;
    logic [7:0]       r_tick_count;

    logic             w_running;
    logic             w_tick;
    logic             w_xfer;
    logic [CNT_W-1:0] w_cfg_eff;
    logic [CNT_W:0]   w_high_len;

    assign w_running  = (r_state != IDLE);
    assign w_tick     = w_running && (r_cnt == r_div - CNT_W'(1));
    assign w_xfer     = cfg_valid && !r_pending;
    assign w_cfg_eff  = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;
    // One extra bit so div+1 cannot wrap at the top of the range.
    assign w_high_len = ({1'b0, r_div} + (CNT_W+1)'(1)) >> 1;

    assign tick       = w_tick;
    assign running    = w_running;
    assign clk_out    = w_running && ({1'b0, r_cnt} < w_high_len);
    assign cfg_ready  = !r_pending;
    assign tick_count = r_tick_count;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (start && !stop) w_state_nxt = RUN;
            RUN:      if (stop) w_state_nxt = STOPPING;
            STOPPING: begin
                if (w_tick)               w_state_nxt = IDLE;
                else if (start && !stop)  w_state_nxt = RUN;
            end
            default:  w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_div        <= CNT_W'(DEFAULT_DIV);
            r_shadow     <= '0;
            r_pending    <= 1'b0;
            r_tick_count <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (!w_running || w_tick) r_cnt <= '0;
            else                      r_cnt <= r_cnt + CNT_W'(1);

            if (w_tick) r_tick_count <= r_tick_count + 8'd1;

            if (w_tick && r_pending) begin
                r_div     <= r_shadow;
                r_pending <= 1'b0;
            end

            // A transfer needs !pending, so it never collides with the shadow copy above.
            if (w_xfer) begin
                if (!w_running) begin
                    r_div <= w_cfg_eff;
                end else begin
                    r_shadow  <= w_cfg_eff;
                    r_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: expected ticks are queued from period arithmetic
// as stimulus is driven, and a negedge monitor pops and compares them as the DUT ticks.
module tb_clk_div_ctrl;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_div;
    logic             start;
    logic             stop;
    logic             tick;
    logic             clk_out;
    logic             running;
    logic [7:0]       tick_count;

    clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_div    (cfg_div),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .clk_out    (clk_out),
        .running    (running),
        .tick_count (tick_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int tc;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         ncyc     = 0;
    int         pos      = 0;
    int         s        = 0;
    logic [7:0] exp_tc   = 8'd0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    exp_t e;
    always @(negedge clk) begin
        ncyc++;
        if (tick === 1'b1) begin
            if (sb.size() == 0) begin
                check("tick_unexpected", int'(tick), 0);
            end else begin
                e = sb.pop_front();
                check("tick_cycle", ncyc, e.cyc);
                check("tick_count_at_tick", int'(tick_count), e.tc);
            end
        end else if (sb.size() != 0 && sb[0].cyc <= ncyc) begin
            e = sb.pop_front();
            check("tick_missing", int'(tick), 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        pos++;
    endtask

    task automatic push_tick();
        sb.push_back('{cyc: s + pos, tc: int'(exp_tc)});
        exp_tc++;
    endtask

    task automatic run_to(input int p, input int d);
        while (pos < p) begin
            step();
            if (pos % d == d - 1) push_tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        exp_tc = 8'd0;
        check("rst_tick", int'(tick), 0);
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_running", int'(running), 0);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        check("rst_tick_count", int'(tick_count), 0);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
        pos = 0;
        s = ncyc + 1;
    endtask

    task automatic cfg_send(input int v);
        cfg_div   = CNT_W'(v);
        cfg_valid = 1'b1;
        check("cfg_ready_offer", int'(cfg_ready), 1);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic run_check_clk(input int n, input int d);
        for (int i = 0; i < n; i++) begin
            check("clk_out_shape", int'(clk_out), int'((pos % d) < (d + 1) / 2));
            check("running_on", int'(running), 1);
            run_to(pos + 1, d);
        end
    endtask

    // Request stop now; the current period completes, then the block must go idle.
    task automatic stop_drain(input int d);
        bit done;
        done = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stopping_running", int'(running), 1);
        if (pos % d == d - 1) begin
            push_tick();
            done = 1'b1;
        end
        while (!done) begin
            step();
            if (pos % d == d - 1) begin
                push_tick();
                done = 1'b1;
            end
        end
        step();
        check("idle_running", int'(running), 0);
        check("idle_clk_out", int'(clk_out), 0);
        repeat (4) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_div = '0; start = 1'b0; stop = 1'b0;

        // Default ratio 10, then stop at cnt=2: final period completes.
        do_reset();
        start_pulse();
        run_check_clk(10, 10);
        run_to(32, 10);
        stop_drain(10);
        check("t4_tick_count_kept", int'(tick_count), int'(exp_tc));

        // Stop at cnt=2, re-start at cnt=5: no gap, no extra tick.
        start_pulse();
        run_to(2, 10);
        stop = 1'b1; step(); stop = 1'b0;
        run_to(5, 10);
        start = 1'b1; step(); start = 1'b0;
        check("t4_resumed_running", int'(running), 1);
        run_to(20, 10);
        stop_drain(10);

        // Mid-run ratio change takes effect only after the current period.
        do_reset();
        start_pulse();
        run_to(4, 10);
        cfg_send(4);
        check("t3_ready_pending", int'(cfg_ready), 0);
        run_to(9, 10);
        check("t3_ready_tick_cycle", int'(cfg_ready), 0);
        step();
        check("t3_ready_after_tick", int'(cfg_ready), 1);
        s   = s + pos;
        pos = 0;
        run_check_clk(8, 4);
        stop_drain(4);

        // Idle ratio write is immediate.
        cfg_send(3);
        check("t2_ready_idle", int'(cfg_ready), 1);
        start_pulse();
        run_check_clk(6, 3);
        stop_drain(3);

        // Ratios 0 and 1 clamp to 2.
        cfg_send(0);
        start_pulse();
        run_check_clk(6, 2);
        stop_drain(2);
        cfg_send(1);
        start_pulse();
        run_check_clk(6, 2);
        stop_drain(2);

        // Reset mid-period with a pending ratio: pending discarded, div back to 10.
        do_reset();
        start_pulse();
        run_to(3, 10);
        cfg_send(5);
        check("t6_pending", int'(cfg_ready), 0);
        run_to(6, 10);
        do_reset();
        start_pulse();
        run_check_clk(10, 10);
        run_to(20, 10);
        stop_drain(10);

        // 256 ticks wrap tick_count back to zero.
        do_reset();
        cfg_send(2);
        start_pulse();
        run_to(512, 2);
        check("t6_wrap", int'(tick_count), 0);
        stop_drain(2);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
